// File: rtl/branch_resolve_pkg.sv
// branch_resolve_pkg: shared types for EX-stage branch resolution
package branch_resolve_pkg;

    typedef enum logic [1:0] {
        BK_NONE,
        BK_BR,
        BK_JAL,
        BK_JALR
    } br_kind_t;

    typedef enum logic {
        BRS_IDLE,
        BRS_REDIR
    } br_res_state_t;

    localparam int PC_W = 32;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] pc;
    } redirect_t;

endpackage

// File: rtl/branch_resolve_target_calc.sv
// br_target_calc: control-transfer target, unconditional-taken flag and target bit1 check
module br_target_calc
    import branch_resolve_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  br_kind_t        kind,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] tgt,
    output logic            taken_nonbr,
    output logic            misalign
);

    logic [XLEN-1:0] sum;

    // JALR adds to rs1 and clears bit0; everything else is pc-relative
    always_comb begin
        sum         = (kind == BK_JALR ? rs1 : pc) + imm;
        tgt         = kind == BK_JALR ? {sum[XLEN-1:1], 1'b0} : sum;
        taken_nonbr = kind == BK_JAL || kind == BK_JALR;
        misalign    = tgt[1];
    end

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage branch resolution, mispredict flush/redirect; BR_PERF_EN adds perf counters
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int XLEN = 32
`ifdef BR_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef BR_PERF_EN
    output logic [CNT_W-1:0] perf_br_cnt,
    output logic [CNT_W-1:0] perf_mispred_cnt,
`endif
    input  logic            in_valid,
    output logic            in_ready,
    input  br_kind_t        in_kind,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_rs1,
    input  logic            in_pred_taken,
    input  logic [XLEN-1:0] in_pred_target,
    input  logic            br_en,
    output logic            flush,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    output logic            out_taken,
    output logic [XLEN-1:0] out_link,
    output logic            out_misalign
);

    br_res_state_t   state, state_nx;
    logic [XLEN-1:0] tgt, link, actual, predicted;
    logic            taken_nonbr, tgt_mis, taken, misalign, fire, mispred;

    br_target_calc #(.XLEN(XLEN)) u_calc (
        .kind        (in_kind),
        .pc          (in_pc),
        .imm         (in_imm),
        .rs1         (in_rs1),
        .tgt         (tgt),
        .taken_nonbr (taken_nonbr),
        .misalign    (tgt_mis)
    );

    // resolve the instruction, detect mispredict and pick the next FSM state
    always_comb begin
        in_ready       = state == BRS_IDLE;
        redirect_valid = state == BRS_REDIR;
        fire           = in_valid && in_ready;
        taken          = in_kind == BK_BR ? br_en : taken_nonbr;
        link           = in_pc + XLEN'(4);
        actual         = taken ? tgt : link;
        predicted      = in_pred_taken ? in_pred_target : link;
        misalign       = taken && tgt_mis;
        mispred        = fire && actual != predicted && !misalign;
        flush          = redirect_valid || (fire && (mispred || misalign));
        state_nx       = redirect_valid ? (redirect_ready ? BRS_IDLE : BRS_REDIR)
                                        : (mispred ? BRS_REDIR : BRS_IDLE);
    end

    // state register; reset drops any pending redirect
    always_ff @(posedge clk) begin
        state <= !rst_n ? BRS_IDLE : state_nx;
    end

    // capture the corrected PC when a mispredict is detected
    always_ff @(posedge clk) begin
        if (!rst_n) redirect_pc <= '0;
        else if (mispred) redirect_pc <= actual;
    end

    // EX/MEM result register, one-cycle latency from fire
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_taken    <= 1'b0;
            out_link     <= '0;
            out_misalign <= 1'b0;
        end else begin
            out_valid <= fire;
            if (fire) begin
                out_taken    <= taken;
                out_link     <= link;
                out_misalign <= misalign;
            end
        end
    end

`ifdef BR_PERF_EN
    // control-transfer and mispredict event counters, wrapping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_br_cnt      <= '0;
            perf_mispred_cnt <= '0;
        end else begin
            if (fire && in_kind != BK_NONE) perf_br_cnt <= perf_br_cnt + CNT_W'(1);
            if (mispred) perf_mispred_cnt <= perf_mispred_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
